// File: rtl/train_seq_pkg.sv
// Shared definitions for the training-loop sequencer.
//   state_t      : FSM state encoding
//   DEF_*        : default widths and phase timeout used by train_sequencer
package train_seq_pkg;

    localparam int DEF_EPOCH_W = 8;
    localparam int DEF_FINAL_W = 23;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FWD,
        S_EVAL,
        S_BWD,
        S_UPD,
        S_ERR,
        S_DONE
    } state_t;

endpackage

// File: rtl/train_sequencer_phase_timer.sv
// phase_timer: cycle counter for the forward/backprop phases.
//   clk_i, rst_i : clock, async active-low reset
//   clr_i        : force count to zero (priority over en_i)
//   en_i         : count one cycle spent in the phase
//   expired_o    : current cycle is the TIMEOUT-th cycle of the phase
module phase_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    // Count holds the number of completed phase cycles, so it equals
    // TIMEOUT-1 during the last permitted cycle; the FSM leaves on that edge.
    assign expired_o = (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i && !expired_o) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/train_sequencer.sv
// train_sequencer: epoch loop controller for the 4-2-1 training datapath.
// Runs CLEAR -> FWD -> EVAL -> BWD -> UPD per epoch until convergence,
// budget exhaustion, phase timeout or abort.
//   clk_i, rst_i          : clock, async active-low reset
//   start_i, abort_i      : run request (IDLE only) / synchronous abort
//   epochs_i, target_i,
//   thresh_i              : run configuration, latched on accepted start
//   final_i               : output-neuron result, compared in EVAL
//   f_end_i, b_end_i      : forward / backprop completion levels
//   zero_o                : one-cycle accumulator clear
//   f0_pass_o, f1_pass_o  : forward pass on initial / updated weights
//   b_pass_o              : backprop enable
//   busy_o, done_o        : run active / one-cycle completion pulse
//   converged_o, timeout_o: run termination reason
//   epoch_o               : completed-epoch count
module train_sequencer
    import train_seq_pkg::*;
#(
    parameter int EPOCH_W = DEF_EPOCH_W,
    parameter int FINAL_W = DEF_FINAL_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [EPOCH_W-1:0] epochs_i,
    input  logic [FINAL_W-1:0] target_i,
    input  logic [FINAL_W-1:0] thresh_i,
    input  logic [FINAL_W-1:0] final_i,
    input  logic               f_end_i,
    input  logic               b_end_i,
    output logic               zero_o,
    output logic               f0_pass_o,
    output logic               f1_pass_o,
    output logic               b_pass_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               converged_o,
    output logic               timeout_o,
    output logic [EPOCH_W-1:0] epoch_o
);

    state_t             state, nxt;
    logic [EPOCH_W-1:0] epochs_q;
    logic [EPOCH_W-1:0] epoch_inc;
    logic [FINAL_W-1:0] target_q;
    logic [FINAL_W-1:0] thresh_q;
    logic               first;
    logic               in_phase;
    logic               expired;
    logic               conv_hit;
    logic               start_ok;
    logic [FINAL_W:0]   sub;
    logic [FINAL_W:0]   mag;

    // One extra bit keeps the sign of final - target; the magnitude of a
    // difference of two FINAL_W-bit values always fits in FINAL_W+1 bits.
    assign sub       = {1'b0, final_i} - {1'b0, target_q};
    assign mag       = sub[FINAL_W] ? -sub : sub;
    assign conv_hit  = (mag <= {1'b0, thresh_q});
    assign epoch_inc = epoch_o + EPOCH_W'(1);
    assign in_phase  = (state == S_FWD) || (state == S_BWD);
    assign start_ok  = (state == S_IDLE) && start_i && !abort_i;

    // Timer is held at zero outside the phases, so it starts fresh on
    // every FWD/BWD entry.
    phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (!in_phase),
        .en_i      (in_phase),
        .expired_o (expired)
    );

    always_comb begin
        nxt = state;
        if (abort_i && state != S_IDLE) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_ok) nxt = (epochs_i == '0) ? S_DONE : S_CLEAR;
                S_CLEAR: nxt = S_FWD;
                // End signal beats a coincident timeout.
                S_FWD:   if (f_end_i) nxt = S_EVAL; else if (expired) nxt = S_ERR;
                S_EVAL:  nxt = conv_hit ? S_DONE : S_BWD;
                S_BWD:   if (b_end_i) nxt = S_UPD; else if (expired) nxt = S_ERR;
                S_UPD:   nxt = (epoch_inc == epochs_q) ? S_DONE : S_CLEAR;
                S_ERR:   nxt = S_DONE;
                S_DONE:  nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so each one is aligned
    // with the state it belongs to.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            epochs_q    <= '0;
            target_q    <= '0;
            thresh_q    <= '0;
            first       <= 1'b0;
            epoch_o     <= '0;
            converged_o <= 1'b0;
            timeout_o   <= 1'b0;
            zero_o      <= 1'b0;
            f0_pass_o   <= 1'b0;
            f1_pass_o   <= 1'b0;
            b_pass_o    <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state <= nxt;
            if (start_ok) begin
                epochs_q    <= epochs_i;
                target_q    <= target_i;
                thresh_q    <= thresh_i;
                epoch_o     <= '0;
                converged_o <= 1'b0;
                timeout_o   <= 1'b0;
                first       <= 1'b1;
            end
            if (state == S_UPD && nxt != S_IDLE) begin
                epoch_o <= epoch_inc;
                first   <= 1'b0;
            end
            if (state == S_EVAL && nxt == S_DONE) converged_o <= 1'b1;
            if (nxt == S_ERR)                     timeout_o   <= 1'b1;
            zero_o    <= (nxt == S_CLEAR);
            f0_pass_o <= (nxt == S_FWD) && first;
            f1_pass_o <= (nxt == S_FWD) && !first;
            b_pass_o  <= (nxt == S_BWD);
            busy_o    <= (nxt != S_IDLE);
            done_o    <= (nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer: a per-cycle vector table for the
// normal, convergence and boundary runs, then hand sequences for timeout,
// abort, zero budget, async reset and end-beats-timeout.
module tb_train_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, abort_i, f_end_i, b_end_i;
    logic [7:0]  epochs_i;
    logic [22:0] target_i, thresh_i, final_i;
    logic        zero_o, f0_pass_o, f1_pass_o, b_pass_o, busy_o, done_o;
    logic        converged_o, timeout_o;
    logic [7:0]  epoch_o;
    logic [7:0]  outs;

    int errors = 0;
    int checks = 0;

    train_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .epochs_i(epochs_i), .target_i(target_i), .thresh_i(thresh_i),
        .final_i(final_i), .f_end_i(f_end_i), .b_end_i(b_end_i),
        .zero_o(zero_o), .f0_pass_o(f0_pass_o), .f1_pass_o(f1_pass_o),
        .b_pass_o(b_pass_o), .busy_o(busy_o), .done_o(done_o),
        .converged_o(converged_o), .timeout_o(timeout_o), .epoch_o(epoch_o)
    );

    always #5 clk_i = ~clk_i;

    // {zero, f0, f1, b, busy, done, converged, timeout}
    assign outs = {zero_o, f0_pass_o, f1_pass_o, b_pass_o,
                   busy_o, done_o, converged_o, timeout_o};

    typedef struct {
        logic        start, abort, f_end, b_end;
        logic [7:0]  epochs;
        logic [22:0] target, thresh, fin;
        logic [7:0]  exp_outs;
        logic [7:0]  exp_epoch;
    } vec_t;

    vec_t vecs[$];
    logic [7:0]  cfg_ep;
    logic [22:0] cfg_tg, cfg_th;

    task automatic add(input logic s, a, fe, be, input logic [22:0] fin,
                       input logic [7:0] eo, input logic [7:0] ee);
        vec_t v;
        v.start = s; v.abort = a; v.f_end = fe; v.b_end = be;
        v.epochs = cfg_ep; v.target = cfg_tg; v.thresh = cfg_th; v.fin = fin;
        v.exp_outs = eo; v.exp_epoch = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic s, a, input logic [7:0] ep,
                          input logic [22:0] tg, th, fin, input logic fe, be);
        start_i = s; abort_i = a; epochs_i = ep; target_i = tg;
        thresh_i = th; final_i = fin; f_end_i = fe; b_end_i = be;
    endtask

    // Advance one clock; outputs are then sampled 2 time units past the edge.
    task automatic step;
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        int n;
        rst_i = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset_outs", outs, 8'h00);
        chk("reset_epoch", epoch_o, 0);
        rst_i = 1'b1;
        step;

        // Full run: 3 epochs, never converges (|50-100| > 0).
        cfg_ep = 3; cfg_tg = 100; cfg_th = 0;
        add(1,0,0,0,50, 8'b1000_1000, 0);
        add(0,0,0,0,50, 8'b0100_1000, 0);
        add(0,0,0,0,50, 8'b0100_1000, 0);
        add(0,0,1,0,50, 8'b0000_1000, 0);
        add(0,0,0,0,50, 8'b0001_1000, 0);
        add(0,0,0,0,50, 8'b0001_1000, 0);
        add(0,0,0,1,50, 8'b0000_1000, 0);
        add(0,0,0,0,50, 8'b1000_1000, 1);
        add(1,0,0,0,50, 8'b0010_1000, 1);   // start mid-run ignored
        add(0,0,0,0,50, 8'b0010_1000, 1);
        add(0,0,1,0,50, 8'b0000_1000, 1);
        add(0,0,0,0,50, 8'b0001_1000, 1);
        add(0,0,0,0,50, 8'b0001_1000, 1);
        add(0,0,0,1,50, 8'b0000_1000, 1);
        add(0,0,0,0,50, 8'b1000_1000, 2);
        add(0,0,0,0,50, 8'b0010_1000, 2);
        add(0,0,0,0,50, 8'b0010_1000, 2);
        add(0,0,1,0,50, 8'b0000_1000, 2);
        add(0,0,0,0,50, 8'b0001_1000, 2);
        add(0,0,0,0,50, 8'b0001_1000, 2);
        add(0,0,0,1,50, 8'b0000_1000, 2);
        add(0,0,0,0,50, 8'b0000_1100, 3);
        add(0,0,0,0,50, 8'b0000_0000, 3);
        // Converges in epoch 0: |97-100| = 3 <= 4, final below target.
        cfg_ep = 5; cfg_tg = 100; cfg_th = 4;
        add(1,0,0,0,97, 8'b1000_1000, 0);
        add(0,0,0,0,97, 8'b0100_1000, 0);
        add(0,0,1,0,97, 8'b0000_1000, 0);
        add(0,0,0,0,97, 8'b0000_1110, 0);
        add(0,0,0,0,97, 8'b0000_0010, 0);
        // Final above target: diff 6 > 5 continues, diff 5 == thresh converges.
        cfg_ep = 2; cfg_tg = 10; cfg_th = 5;
        add(1,0,0,0,16, 8'b1000_1000, 0);
        add(0,0,0,0,16, 8'b0100_1000, 0);
        add(0,0,1,0,16, 8'b0000_1000, 0);
        add(0,0,0,0,16, 8'b0001_1000, 0);
        add(0,0,0,1,16, 8'b0000_1000, 0);
        add(0,0,0,0,15, 8'b1000_1000, 1);
        add(0,0,0,0,15, 8'b0010_1000, 1);
        add(0,0,1,0,15, 8'b0000_1000, 1);
        add(0,0,0,0,15, 8'b0000_1110, 1);
        add(0,0,0,0,15, 8'b0000_0010, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].start, vecs[i].abort, vecs[i].epochs, vecs[i].target,
                   vecs[i].thresh, vecs[i].fin, vecs[i].f_end, vecs[i].b_end);
            step;
            chk($sformatf("vec%0d_outs", i), outs, vecs[i].exp_outs);
            chk($sformatf("vec%0d_epoch", i), epoch_o, vecs[i].exp_epoch);
        end

        // Zero budget: straight to DONE, no clear or pass.
        set_in(1, 0, 0, 100, 0, 50, 0, 0);
        step;
        chk("ep0_done", outs, 8'b0000_1100);
        start_i = 0;
        step;
        chk("ep0_idle", outs, 8'b0000_0000);

        // Backprop never ends: 64 cycles of b_pass, then ERR, then DONE.
        set_in(1, 0, 2, 100, 0, 50, 1, 0);
        step;
        start_i = 0;
        step; step; step;
        chk("tmo_bwd", outs, 8'b0001_1000);
        n = 0;
        while (b_pass_o && n < 200) begin
            n++;
            step;
        end
        chk("tmo_len", n, 64);
        chk("tmo_err", outs, 8'b0000_1001);
        step;
        chk("tmo_done", outs, 8'b0000_1101);
        step;
        chk("tmo_idle", outs, 8'b0000_0001);
        set_in(1, 0, 1, 100, 0, 50, 1, 1);
        step;
        chk("tmo_cleared", outs, 8'b1000_1000);
        start_i = 0;
        repeat (5) step;
        chk("tmo_rerun_done", outs, 8'b0000_1100);
        chk("tmo_rerun_epoch", epoch_o, 1);
        step;

        // Abort in BWD of epoch 1, with a start pulse mid-run.
        set_in(1, 0, 3, 100, 0, 50, 1, 1);
        step;
        for (int k = 0; k < 8; k++) begin
            start_i = (k == 2);
            step;
        end
        chk("abort_pre", outs, 8'b0001_1000);
        chk("abort_pre_epoch", epoch_o, 1);
        abort_i = 1;
        step;
        chk("abort_idle", outs, 8'b0000_0000);
        chk("abort_epoch", epoch_o, 1);
        abort_i = 0;
        for (int k = 0; k < 4; k++) begin
            step;
            chk("abort_no_done", done_o, 0);
        end

        // Async reset in FWD of epoch 1.
        set_in(1, 0, 3, 100, 0, 50, 1, 1);
        step;
        start_i = 0;
        repeat (5) step;
        f_end_i = 0;
        step;
        chk("rst_pre", outs, 8'b0010_1000);
        chk("rst_pre_epoch", epoch_o, 1);
        #1 rst_i = 0;
        #1;
        chk("rst_async_outs", outs, 8'b0000_0000);
        chk("rst_async_epoch", epoch_o, 0);
        #3 rst_i = 1;
        step;
        chk("rst_stay_idle", outs, 8'b0000_0000);

        // End on the last permitted phase cycle wins over the timeout.
        set_in(1, 0, 1, 100, 0, 50, 0, 0);
        step;
        start_i = 0;
        step;
        repeat (63) step;
        chk("fwd_last_cycle", outs, 8'b0100_1000);
        f_end_i = 1;
        step;
        chk("fwd_end_wins", outs, 8'b0000_1000);
        f_end_i = 0;
        step;
        repeat (63) step;
        chk("bwd_last_cycle", outs, 8'b0001_1000);
        b_end_i = 1;
        step;
        chk("bwd_end_wins", outs, 8'b0000_1000);
        b_end_i = 0;
        step;
        chk("endwin_done", outs, 8'b0000_1100);
        chk("endwin_epoch", epoch_o, 1);
        step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
